fp16_normalize: RTL

Post-add normalize/round stage for the 16-bit FPU. Downstream of the add/sub datapath: it takes an unnormalized sign/exponent/extended-mantissa sum, shifts it to a hidden-1 form one bit per clock, and rounds to nearest-even. It emits an IEEE half-precision `result` with `done` and `OFUF` flags. Denormals are flushed to zero.

---
 rtl/fp16_normalize_if.sv | 21 ++
 rtl/fp16_normalize.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fp16_normalize_if.sv
// rtl/fp16_normalize_if.sv - request/result bundle for the fp16 normalize/round stage
interface fp16_normalize_if;
    logic        start;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [13:0] man_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [1:0]  OFUF;

    modport master (
        output start, sign_in, exp_in, man_in,
        input  busy, done, result, OFUF
    );

    modport slave (
        input  start, sign_in, exp_in, man_in,
        output busy, done, result, OFUF
    );
endinterface

// File: rtl/fp16_normalize.sv
// rtl/fp16_normalize.sv - multicycle normalize and round-to-nearest-even for half precision
module fp16_normalize (
    input  logic              clk,
    input  logic              reset,
    fp16_normalize_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_R,
        SHIFT_L,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    logic        s;
    logic [5:0]  e;
    logic [13:0] m;

    logic        round_up;
    logic [10:0] frac_sum;
    logic [9:0]  f_rnd;
    logic [5:0]  e_rnd;

    // Rounded fraction and exponent from the current working mantissa; only consumed in ROUND.
    always_comb begin
        round_up = m[1] & (m[0] | m[2]);
        frac_sum = {1'b0, m[11:2]} + {10'b0, round_up};
        f_rnd    = frac_sum[9:0];
        e_rnd    = e;
        if (frac_sum[10]) begin
            f_rnd = 10'b0;
            e_rnd = e + 6'd1;
        end
    end

    // Control FSM with all outputs registered; done is raised on entry to DONE so it lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            s          <= 1'b0;
            e          <= 6'd0;
            m          <= 14'd0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= 16'h0000;
            bus.OFUF   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s        <= bus.sign_in;
                        e        <= {1'b0, bus.exp_in};
                        m        <= bus.man_in;
                        bus.busy <= 1'b1;
                        state    <= CHECK;
                    end
                end

                CHECK: begin
                    bus.result <= 16'h0000;
                    bus.OFUF   <= 2'b00;
                    if (m == 14'd0) begin
                        bus.result <= {s, 15'b0};
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (e == 6'd31) begin
                        bus.result <= {s, 5'h1F, 10'b0};
                        bus.OFUF   <= 2'b10;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (e == 6'd0) begin
                        bus.result <= {s, 15'b0};
                        bus.OFUF   <= 2'b01;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (m[13]) begin
                        state <= SHIFT_R;
                    end else if (!m[12]) begin
                        state <= SHIFT_L;
                    end else begin
                        state <= ROUND;
                    end
                end

                SHIFT_R: begin
                    // Carry out of the adder: drop one bit, folding guard into sticky.
                    m     <= {1'b0, m[13:2], m[1] | m[0]};
                    e     <= e + 6'd1;
                    state <= ROUND;
                end

                SHIFT_L: begin
                    if (e == 6'd1 && !m[12]) begin
                        bus.result <= {s, 15'b0};
                        bus.OFUF   <= 2'b01;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        // Sticky stays pinned in bit 0; guard moves up into the fraction.
                        m <= {m[12:1], 1'b0, m[0]};
                        e <= e - 6'd1;
                        if (m[11]) begin
                            state <= ROUND;
                        end
                    end
                end

                ROUND: begin
                    if (e_rnd >= 6'd31) begin
                        bus.result <= {s, 5'h1F, 10'b0};
                        bus.OFUF   <= 2'b10;
                    end else begin
                        bus.result <= {s, e_rnd[4:0], f_rnd};
                        bus.OFUF   <= 2'b00;
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end

                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
